pong_game_ctrl: RTL and testbench

Game-flow controller for the Pong display. It sits beside the VGA sync generator, watches the pixel coordinates to derive a once-per-frame tick, and sequences play through new-game, serve, play and game-over phases. It enables and recentres the ball in the graphics datapath and keeps the lives count and the two-digit BCD score consumed by the text overlay.

---
 rtl/pong_pkg.sv | 22 ++
 rtl/bcd_score_counter.sv | 31 +++
 rtl/pong_game_ctrl.sv | 120 ++++++++++++
 tb/tb_pong_game_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game-flow controller: state encoding,
// default game constants and BCD digit helpers.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_SERVE   = 2'd1,
        ST_PLAY    = 2'd2,
        ST_OVER    = 2'd3
    } game_state_t;

    localparam int LIVES_DEFAULT       = 3;
    localparam int WAIT_FRAMES_DEFAULT = 120;
    localparam int TICK_X_DEFAULT      = 0;
    localparam int TICK_Y_DEFAULT      = 481;
    localparam int BCD_DIGIT_W         = 4;

    function automatic logic [BCD_DIGIT_W-1:0] bcd_digit_inc(input logic [BCD_DIGIT_W-1:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD up-counter for the score; clear has priority, 99 wraps to 00.
module bcd_score_counter
    import pong_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     inc,
    output logic [2*BCD_DIGIT_W-1:0] score_bcd
);

    logic [BCD_DIGIT_W-1:0] ones;
    logic [BCD_DIGIT_W-1:0] tens;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ones <= '0;
            tens <= '0;
        end else if (clr) begin
            ones <= '0;
            tens <= '0;
        end else if (inc) begin
            ones <= bcd_digit_inc(ones);
            // Tens only move on the ones-digit carry
            if (ones == 4'd9) tens <= bcd_digit_inc(tens);
        end
    end

    assign score_bcd = {tens, ones};

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: derives the frame tick from the sync generator's
// coordinates and sequences NEWGAME -> PLAY <-> SERVE -> OVER, with lives and score.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int LIVES       = LIVES_DEFAULT,
    parameter int WAIT_FRAMES = WAIT_FRAMES_DEFAULT,
    parameter int TICK_X      = TICK_X_DEFAULT,
    parameter int TICK_Y      = TICK_Y_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
    output logic       frame_tick,
    output logic       ball_en,
    output logic       ball_rst,
    output logic [7:0] score_bcd,
    output logic [1:0] lives,
    output logic [1:0] state,
    output logic       game_over
);

    localparam int                  TIMER_W    = $clog2(WAIT_FRAMES + 1);
    localparam logic [TIMER_W-1:0]  TIMER_LOAD = TIMER_W'(WAIT_FRAMES);
    localparam logic [1:0]          LIVES_LOAD = 2'(LIVES);

    game_state_t        state_q;
    game_state_t        state_d;
    logic [TIMER_W-1:0] timer;
    logic               tick_match;
    logic               match_q;
    logic               hit_q;
    logic               miss_q;
    logic               hit_p;
    logic               miss_p;
    logic               btn_any;
    logic               timer_zero;

    logic ball_en_d;
    logic ball_rst_d;
    logic game_over_d;
    logic timer_load;
    logic new_game;
    logic score_inc;
    logic lives_dec;

    // The coordinate holds for several clk, so only its first clk counts
    assign tick_match = (pixel_x == 10'(TICK_X)) && (pixel_y == 10'(TICK_Y));
    assign hit_p      = hit && !hit_q;
    assign miss_p     = miss && !miss_q;
    assign btn_any    = |btn;
    assign timer_zero = (timer == '0);
    assign state      = 2'(state_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_NEWGAME;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NEWGAME: if (btn_any) state_d = ST_PLAY;
            ST_PLAY:    if (miss_p) state_d = (lives <= 2'd1) ? ST_OVER : ST_SERVE;
            ST_SERVE:   if (timer_zero && btn_any) state_d = ST_PLAY;
            ST_OVER:    if (timer_zero) state_d = ST_NEWGAME;
            default:    state_d = ST_NEWGAME;
        endcase
    end

    always_comb begin
        ball_en_d   = (state_d == ST_PLAY);
        ball_rst_d  = (state_d == ST_PLAY) && (state_q != ST_PLAY);
        game_over_d = (state_d == ST_OVER);
        timer_load  = (state_d != state_q) && ((state_d == ST_SERVE) || (state_d == ST_OVER));
        new_game    = (state_q == ST_NEWGAME) && btn_any;
        score_inc   = (state_q == ST_PLAY) && hit_p;
        lives_dec   = (state_q == ST_PLAY) && miss_p && (lives != 2'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_q    <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            frame_tick <= 1'b0;
            timer      <= '0;
            lives      <= LIVES_LOAD;
            ball_en    <= 1'b0;
            ball_rst   <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            match_q    <= tick_match;
            hit_q      <= hit;
            miss_q     <= miss;
            frame_tick <= tick_match && !match_q;
            // A fresh load wins over a tick landing in the same clk
            if (timer_load)                    timer <= TIMER_LOAD;
            else if (frame_tick && !timer_zero) timer <= timer - 1'b1;
            if (new_game)       lives <= LIVES_LOAD;
            else if (lives_dec) lives <= lives - 2'd1;
            ball_en    <= ball_en_d;
            ball_rst   <= ball_rst_d;
            game_over  <= game_over_d;
        end
    end

    bcd_score_counter u_score (
        .clk       (clk),
        .reset     (reset),
        .clr       (new_game),
        .inc       (score_inc),
        .score_bcd (score_bcd)
    );

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed game scenarios plus random
// play, compared every cycle against an integer-level game model.
module tb_pong_game_ctrl;

    localparam int LIVES       = 3;
    localparam int WAIT_FRAMES = 120;
    localparam int TICK_X      = 0;
    localparam int TICK_Y      = 481;

    localparam int PH_NEWGAME = 0;
    localparam int PH_SERVE   = 1;
    localparam int PH_PLAY    = 2;
    localparam int PH_OVER    = 3;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [1:0] btn;
    logic       hit;
    logic       miss;
    logic       frame_tick;
    logic       ball_en;
    logic       ball_rst;
    logic [7:0] score_bcd;
    logic [1:0] lives;
    logic [1:0] state;
    logic       game_over;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .LIVES       (LIVES),
        .WAIT_FRAMES (WAIT_FRAMES),
        .TICK_X      (TICK_X),
        .TICK_Y      (TICK_Y)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .btn        (btn),
        .hit        (hit),
        .miss       (miss),
        .frame_tick (frame_tick),
        .ball_en    (ball_en),
        .ball_rst   (ball_rst),
        .score_bcd  (score_bcd),
        .lives      (lives),
        .state      (state),
        .game_over  (game_over)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Score is kept as a plain integer 0..99 and converted to BCD for comparison.
    int m_phase, m_timer, m_lives, m_score;
    bit m_tick, m_ball_en, m_ball_rst, m_game_over;
    bit m_prev_match, m_prev_hit, m_prev_miss;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = PH_NEWGAME; m_timer = 0; m_lives = LIVES; m_score = 0;
            m_tick = 0; m_ball_en = 0; m_ball_rst = 0; m_game_over = 0;
            m_prev_match = 0; m_prev_hit = 0; m_prev_miss = 0;
        end else begin
            bit match, hit_e, miss_e, press;
            int nxt;
            match  = (int'(pixel_x) == TICK_X) && (int'(pixel_y) == TICK_Y);
            hit_e  = hit && !m_prev_hit;
            miss_e = miss && !m_prev_miss;
            press  = (btn != 2'b00);
            nxt    = m_phase;
            case (m_phase)
                PH_NEWGAME: if (press) begin m_score = 0; m_lives = LIVES; nxt = PH_PLAY; end
                PH_PLAY: begin
                    if (hit_e) m_score = (m_score + 1) % 100;
                    if (miss_e) begin
                        if (m_lives > 0) m_lives = m_lives - 1;
                        nxt = (m_lives == 0) ? PH_OVER : PH_SERVE;
                    end
                end
                PH_SERVE: if (m_timer == 0 && press) nxt = PH_PLAY;
                default:  if (m_timer == 0) nxt = PH_NEWGAME;
            endcase
            if (nxt != m_phase && (nxt == PH_SERVE || nxt == PH_OVER)) m_timer = WAIT_FRAMES;
            else if (m_tick && m_timer > 0) m_timer = m_timer - 1;
            m_ball_rst   = (nxt == PH_PLAY) && (m_phase != PH_PLAY);
            m_ball_en    = (nxt == PH_PLAY);
            m_game_over  = (nxt == PH_OVER);
            m_phase      = nxt;
            m_tick       = match && !m_prev_match;
            m_prev_match = match;
            m_prev_hit   = hit;
            m_prev_miss  = miss;
        end
    end

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    // Cycle-by-cycle comparison on the inactive edge
    initial begin
        forever begin
            @(negedge clk);
            check("m_state",     32'(state),      32'(m_phase));
            check("m_lives",     32'(lives),      32'(m_lives));
            check("m_score",     32'(score_bcd),  32'(to_bcd(m_score)));
            check("m_ball_en",   32'(ball_en),    32'(m_ball_en));
            check("m_ball_rst",  32'(ball_rst),   32'(m_ball_rst));
            check("m_game_over", 32'(game_over),  32'(m_game_over));
            check("m_frame_tick",32'(frame_tick), 32'(m_tick));
        end
    end

    // ---------------- pixel coordinate generator (compressed frame) ----------------
    initial begin
        pixel_x = 10'd0;
        pixel_y = 10'd480;
        forever begin
            repeat (4) @(negedge clk);
            if (pixel_x == 10'd3) begin
                pixel_x = 10'd0;
                pixel_y = (pixel_y == 10'd482) ? 10'd480 : pixel_y + 10'd1;
            end else begin
                pixel_x = pixel_x + 10'd1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_hit(input int width);
        hit = 1'b1;
        cycles(width);
        hit = 1'b0;
        cycles(2);
    endtask

    task automatic wait_state(input string tag, input logic [1:0] target, input int budget,
                              input bit jitter, output int ticks);
        int n;
        ticks = 0;
        n = 0;
        while (state !== target && n < budget) begin
            if (frame_tick) ticks++;
            if (jitter) begin
                hit  = ($urandom_range(0, 2) == 0);
                miss = ($urandom_range(0, 4) == 0);
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_reached"}, 32'(state), 32'(target));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},     32'(state),      32'(PH_NEWGAME));
        check({tag, "_lives"},     32'(lives),      32'(LIVES));
        check({tag, "_score"},     32'(score_bcd),  32'h00);
        check({tag, "_ball_en"},   32'(ball_en),    32'h0);
        check({tag, "_ball_rst"},  32'(ball_rst),   32'h0);
        check({tag, "_game_over"}, 32'(game_over),  32'h0);
        check({tag, "_frame_tick"},32'(frame_tick), 32'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog simulation did not complete t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int ticks, doubles;
        bit prev_tick;
        reset = 1'b1;
        btn   = 2'b00;
        hit   = 1'b0;
        miss  = 1'b0;
        cycles(3);
        check_reset_values("reset");
        reset = 1'b0;

        // One single-clk tick per frame (frame = 48 clk here)
        ticks = 0; doubles = 0; prev_tick = 0;
        for (int i = 0; i < 240; i++) begin
            cycles(1);
            if (frame_tick) ticks++;
            if (frame_tick && prev_tick) doubles++;
            prev_tick = frame_tick;
        end
        check("tick_count", 32'(ticks), 32'd5);
        check("tick_width", 32'(doubles), 32'd0);
        check("idle_state", 32'(state), 32'(PH_NEWGAME));

        // Start a game
        btn = 2'b01;
        cycles(1);
        btn = 2'b00;
        check("start_state",    32'(state),    32'(PH_PLAY));
        check("start_ball_en",  32'(ball_en),  32'h1);
        check("start_ball_rst", 32'(ball_rst), 32'h1);
        check("start_lives",    32'(lives),    32'(LIVES));
        cycles(1);
        check("start_rst_pulse", 32'(ball_rst), 32'h0);

        for (int i = 0; i < 12; i++) pulse_hit(4);
        check("score_12", 32'(score_bcd), 32'h12);
        for (int i = 0; i < 87; i++) pulse_hit(1 + $urandom_range(0, 3));
        check("score_99", 32'(score_bcd), 32'h99);
        pulse_hit(4);
        check("score_wrap", 32'(score_bcd), 32'h00);

        // First miss with a button held through SERVE
        btn  = 2'b10;
        miss = 1'b1;
        cycles(1);
        check("miss1_state",   32'(state),   32'(PH_SERVE));
        check("miss1_lives",   32'(lives),   32'd2);
        check("miss1_ball_en", 32'(ball_en), 32'h0);
        wait_state("serve1", 2'(PH_PLAY), 200 * 48, 1'b0, ticks);
        check("serve1_ticks",    32'(ticks),    32'(WAIT_FRAMES));
        check("serve1_ball_rst", 32'(ball_rst), 32'h1);
        btn  = 2'b00;
        miss = 1'b0;

        // Simultaneous hit and miss with two lives left
        cycles(2);
        hit  = 1'b1;
        miss = 1'b1;
        cycles(1);
        hit  = 1'b0;
        miss = 1'b0;
        check("both_score", 32'(score_bcd), 32'h01);
        check("both_lives", 32'(lives),     32'd1);
        check("both_state", 32'(state),     32'(PH_SERVE));
        btn = 2'b01;
        wait_state("serve2", 2'(PH_PLAY), 200 * 48, 1'b0, ticks);
        check("serve2_ticks", 32'(ticks), 32'(WAIT_FRAMES));
        btn = 2'b00;

        // Last life lost; hit/miss activity during OVER must be ignored
        cycles(2);
        miss = 1'b1;
        cycles(1);
        check("over_state",     32'(state),     32'(PH_OVER));
        check("over_lives",     32'(lives),     32'd0);
        check("over_game_over", 32'(game_over), 32'h1);
        check("over_ball_en",   32'(ball_en),   32'h0);
        wait_state("over", 2'(PH_NEWGAME), 200 * 48, 1'b1, ticks);
        hit  = 1'b0;
        miss = 1'b0;
        check("over_ticks",      32'(ticks),     32'(WAIT_FRAMES));
        check("over_hold_score", 32'(score_bcd), 32'h01);
        check("over_hold_lives", 32'(lives),     32'd0);
        check("over_exit_flag",  32'(game_over), 32'h0);

        // New game then asynchronous reset mid-PLAY
        cycles(2);
        btn = 2'b11;
        cycles(1);
        btn = 2'b00;
        check("new_state", 32'(state),     32'(PH_PLAY));
        check("new_score", 32'(score_bcd), 32'h00);
        check("new_lives", 32'(lives),     32'(LIVES));
        for (int i = 0; i < 5; i++) pulse_hit(2);
        check("replay_score", 32'(score_bcd), 32'h05);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        cycles(2);
        reset = 1'b0;

        // Random play against the model
        for (int i = 0; i < 8000; i++) begin
            btn  = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            hit  = ($urandom_range(0, 3) == 0);
            miss = ($urandom_range(0, 60) == 0);
            cycles(1);
        end
        btn  = 2'b00;
        hit  = 1'b0;
        miss = 1'b0;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
